// File: rtl/solo_squash_io_ctrl_if.sv
// Pad-side signal bundle of the solo squash I/O controller.
// The master modport is the board/pad side; the slave modport is the controller.
interface solo_squash_io_ctrl_if;
  localparam int unsigned NBTN = 4;
  localparam int unsigned NOEB = 6;

  logic            ext_reset_n;
  logic [NBTN-1:0] buttons_n_in;
  logic            game_reset;
  logic [NBTN-1:0] buttons_n_out;
  logic [NBTN-1:0] press;
  logic [NOEB-1:0] oeb;
  logic            running;

  modport master (
    output ext_reset_n, buttons_n_in,
    input  game_reset, buttons_n_out, press, oeb, running
  );

  modport slave (
    input  ext_reset_n, buttons_n_in,
    output game_reset, buttons_n_out, press, oeb, running
  );
endinterface

// File: rtl/solo_squash_io_ctrl.sv
// Solo squash I/O controller: external reset release sequencing, output-enable
// gating, and per-button synchronise/debounce with press-pulse generation.
module solo_squash_io_ctrl #(
  parameter int unsigned RESET_HOLD      = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                 clk,
  input  logic                 reset,
  solo_squash_io_ctrl_if.slave io
);
  localparam int unsigned NBTN = 4;
  localparam int unsigned NOEB = 6;
  localparam int unsigned HW   = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int unsigned DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_ASSERT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic            ext_s1_q, ext_s1_d;
  logic            ext_sync_q, ext_sync_d;
  logic [NBTN-1:0] btn_s1_q, btn_s1_d;
  logic [NBTN-1:0] btn_sync_q, btn_sync_d;
  logic [NBTN-1:0] stable_q, stable_d;
  logic [DW-1:0]   dcnt_q [NBTN];
  logic [DW-1:0]   dcnt_d [NBTN];
  logic [NBTN-1:0] press_q, press_d;
  logic            game_reset_q, game_reset_d;
  logic [NOEB-1:0] oeb_q, oeb_d;
  logic            running_q, running_d;
  logic            run_d;

  // Synchronisers and the reset-release FSM
  always_comb begin
    ext_s1_d   = io.ext_reset_n;
    ext_sync_d = ext_s1_q;
    btn_s1_d   = io.buttons_n_in;
    btn_sync_d = btn_s1_q;
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    case (state_q)
      ST_ASSERT: begin
        if (!ext_sync_q) begin
          hcnt_d = '0;
        end else if (hcnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      ST_RUN: begin
        if (!ext_sync_q) begin
          state_d = ST_ASSERT;
          hcnt_d  = '0;
        end
      end
    endcase
  end

  // Debounce: a change is accepted only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NBTN; i++) begin
      dcnt_d[i] = '0;
      if (btn_sync_q[i] != stable_q[i]) begin
        if (dcnt_q[i] == DB_LAST) begin
          stable_d[i] = btn_sync_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Outputs registered from next state so they line up with the state flop
  always_comb begin
    run_d        = (state_d == ST_RUN);
    game_reset_d = !run_d;
    running_d    = run_d;
    oeb_d        = run_d ? {NOEB{1'b0}} : {NOEB{1'b1}};
    press_d      = stable_q & ~stable_d & {NBTN{run_d}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ASSERT;
      hcnt_q       <= '0;
      ext_s1_q     <= 1'b0;
      ext_sync_q   <= 1'b0;
      btn_s1_q     <= {NBTN{1'b1}};
      btn_sync_q   <= {NBTN{1'b1}};
      stable_q     <= {NBTN{1'b1}};
      for (int i = 0; i < NBTN; i++) dcnt_q[i] <= '0;
      press_q      <= '0;
      game_reset_q <= 1'b1;
      oeb_q        <= {NOEB{1'b1}};
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      ext_s1_q     <= ext_s1_d;
      ext_sync_q   <= ext_sync_d;
      btn_s1_q     <= btn_s1_d;
      btn_sync_q   <= btn_sync_d;
      stable_q     <= stable_d;
      for (int i = 0; i < NBTN; i++) dcnt_q[i] <= dcnt_d[i];
      press_q      <= press_d;
      game_reset_q <= game_reset_d;
      oeb_q        <= oeb_d;
      running_q    <= running_d;
    end
  end

  assign io.game_reset    = game_reset_q;
  assign io.buttons_n_out = stable_q;
  assign io.press         = press_q;
  assign io.oeb           = oeb_q;
  assign io.running       = running_q;
endmodule
